// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller and its ALU decoder.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN adds the sticky ILLEGAL trap state.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_JAL     = 4'd9,
    S_BEQ     = 4'd10
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , S_ILLEGAL = 4'd11
`endif
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_XOR = 3'b100;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Shift and SLTU encodings have no ALU support in this core.
  function automatic logic funct3_reserved(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b011) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct decode to the 3-bit ALUControl command.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_t     alu_op_i,
  input  logic [2:0]  funct3_i,
  input  logic        op5_i,
  input  logic        funct7b5_i,
  output logic [2:0]  alu_control_o
);

  // funct3 lookup, with SUB only for R-type carrying funct7[5]
  always_comb begin
    alu_control_o = ALUCTL_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALUCTL_ADD;
      ALUOP_SUB: alu_control_o = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            if (op5_i && funct7b5_i) begin
              alu_control_o = ALUCTL_SUB;
            end else begin
              alu_control_o = ALUCTL_ADD;
            end
          end
          3'b010:  alu_control_o = ALUCTL_SLT;
          3'b100:  alu_control_o = ALUCTL_XOR;
          3'b110:  alu_control_o = ALUCTL_OR;
          3'b111:  alu_control_o = ALUCTL_AND;
          default: alu_control_o = ALUCTL_ADD;
        endcase
      end
      default: alu_control_o = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM driving the shared-ALU datapath.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN enables the sticky illegal-instruction trap.
module multicycle_controller
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalInstr
);

  ctrl_state_t state_q, state_d;

  alu_op_t     alu_op_s;
  logic        pc_update_s;
  logic        branch_s;
  logic        adr_src_s;
  logic        mem_write_s;
  logic        ir_write_s;
  logic        reg_write_s;
  logic [1:0]  result_src_s;
  logic [1:0]  alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [1:0]  imm_src_s;
  logic [2:0]  alu_control_s;
  logic        illegal_s;

  // State register; reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d      = S_FETCH;
    alu_op_s     = ALUOP_ADD;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    illegal_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        pc_update_s  = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jump target off OldPC while the opcode resolves
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          OP_RTYPE: state_d = funct3_reserved(funct3) ? S_ILLEGAL : S_EXECR;
          OP_ITYPE: state_d = funct3_reserved(funct3) ? S_ILLEGAL : S_EXECI;
`else
          OP_RTYPE: state_d = S_EXECR;
          OP_ITYPE: state_d = S_EXECI;
`endif
          OP_JAL:    state_d = S_JAL;
          OP_BRANCH: state_d = S_BEQ;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:   state_d = S_ILLEGAL;
`else
          default:   state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        state_d     = op[5] ? S_MEMWR : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = ALUOP_SUB;
        branch_s    = 1'b1;
        state_d     = S_FETCH;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: begin
        illegal_s = 1'b1;
        state_d   = S_ILLEGAL;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Immediate format depends on the opcode alone
  always_comb begin
    imm_src_s = IMM_I;
    case (op)
      OP_STORE:  imm_src_s = IMM_S;
      OP_BRANCH: imm_src_s = IMM_B;
      OP_JAL:    imm_src_s = IMM_J;
      default:   imm_src_s = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op_s),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_control_s)
  );

  // Reset masks every output so no strobe escapes an aborted instruction
  always_comb begin
    if (reset) begin
      PCWrite      = 1'b0;
      AdrSrc       = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ImmSrc       = 2'b00;
      ALUControl   = 3'b000;
      IllegalInstr = 1'b0;
    end else begin
      PCWrite      = pc_update_s | (branch_s & Zero);
      AdrSrc       = adr_src_s;
      MemWrite     = mem_write_s;
      IRWrite      = ir_write_s;
      RegWrite     = reg_write_s;
      ResultSrc    = result_src_s;
      ALUSrcA      = alu_src_a_s;
      ALUSrcB      = alu_src_b_s;
      ImmSrc       = imm_src_s;
      ALUControl   = alu_control_s;
      IllegalInstr = illegal_s;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases plus random instruction stream.
// Honours MC_CTRL_ILLEGAL_TRAP_EN so the same bench covers both builds.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .IllegalInstr(IllegalInstr)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, XOR_ = 3'd4, SLT = 3'd5;

  function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] im, input logic [2:0] alu,
                                    input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, im, alu, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    else if (o == BQ) return 2'b10;
    else if (o == JL) return 2'b11;
    else return 2'b00;
  endfunction

  // Arithmetic operation an ALU-class instruction should request
  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? SUB : ADD;
      3'b010:  return SLT;
      3'b100:  return XOR_;
      3'b110:  return OR_;
      3'b111:  return AND_;
      default: return ADD;
    endcase
  endfunction

  function automatic logic [16:0] observed();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, ALUControl, IllegalInstr};
  endfunction

  task automatic check(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Per-cycle expected control vectors for one instruction, FETCH first
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int trap_cycles);
    logic [1:0] im;
    im = imm_of(o);
    exp_q.delete();
    exp_q.push_back(v(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im, ADD, 0));
    exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, ADD, 0));
    if (trap_cycles > 0) begin
      for (int k = 0; k < trap_cycles; k++)
        exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ADD, 1));
    end else begin
      case (o)
        LW: begin
          exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ADD, 0));
          exp_q.push_back(v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ADD, 0));
          exp_q.push_back(v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, ADD, 0));
        end
        SW: begin
          exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ADD, 0));
          exp_q.push_back(v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, ADD, 0));
        end
        RT, IT: begin
          exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == IT) ? 2'b01 : 2'b00, im,
                            alu_of(o, f3, f7), 0));
          exp_q.push_back(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, ADD, 0));
        end
        JL: begin
          exp_q.push_back(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, ADD, 0));
          exp_q.push_back(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, ADD, 0));
        end
        BQ: exp_q.push_back(v(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, SUB, 0));
        default: ;
      endcase
    end
  endtask

  // Step one instruction; reset_at = index of the cycle that gets reset instead (-1: none)
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int reset_at,
                           input int trap_cycles);
    build(o, f3, f7, z, trap_cycles);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    for (int i = 0; i <= exp_q.size(); i++) begin
      if (i == reset_at) begin
        reset = 1'b1;
        #1 check({tag, "_reset"}, 17'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      if (i == exp_q.size()) break;
      #1 check($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cls;
    logic [6:0] o;
    logic [2:0] f3;
    logic [6:0] bad_ops [6];
    bad_ops = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b0010111, 7'b1100111, 7'b1110011};

    reset = 1'b1; op = RT; funct3 = 3'b111; funct7b5 = 1'b1; Zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("reset_hold", 17'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    run_instr("sub",      RT, 3'b000, 1'b1, 1'b0, -1, 0);
    run_instr("lw",       LW, 3'b010, 1'b0, 1'b1, -1, 0);
    run_instr("beq_taken",BQ, 3'b000, 1'b0, 1'b1, -1, 0);
    run_instr("beq_nt",   BQ, 3'b000, 1'b0, 1'b0, -1, 0);
    run_instr("sw_abort", SW, 3'b010, 1'b0, 1'b0, 3, 0);
    run_instr("after_rst",IT, 3'b110, 1'b0, 1'b0, -1, 0);
    run_instr("jal",      JL, 3'b000, 1'b0, 1'b1, -1, 0);

    for (int n = 0; n < 60; n++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      cls = $urandom_range(0, 5);
`else
      cls = $urandom_range(0, 6);
`endif
      f3 = 3'($urandom_range(0, 7));
      case (cls)
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = JL;
        5: o = BQ;
        default: o = bad_ops[$urandom_range(0, 5)];
      endcase
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      if ((o == RT || o == IT) && (f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b101))
        f3 = f3 & 3'b110;
`endif
      run_instr($sformatf("rnd%0d", n), o, f3, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, 0);
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    run_instr("ill_op",  7'b1111111, 3'b000, 1'b0, 1'b1, 6, 4);
    run_instr("ill_f3",  RT, 3'b101, 1'b1, 1'b0, 5, 3);
    run_instr("ill_f3i", IT, 3'b001, 1'b0, 1'b0, 4, 2);
`else
    run_instr("nop_op",  7'b1111111, 3'b000, 1'b0, 1'b1, -1, 0);
    run_instr("f3_add",  RT, 3'b101, 1'b1, 1'b0, -1, 0);
    run_instr("f3i_add", IT, 3'b001, 1'b0, 1'b0, -1, 0);
`endif
    run_instr("final",   BQ, 3'b000, 1'b0, 1'b1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
